audio_serial_capture: RTL and testbench
=======================================

AUDIO_SERIAL_CAPTURE -- requirements
Module: audio_serial_capture

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 16: bits per channel sample.
REQ-002 SHALL have parameter BCLK_PER_HALF, default 32: expected bclk rising edges per lrck half-period.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2: consecutive good frames needed to assert locked.
REQ-004 SHALL have port wclock, input, 1: sole clock; FIFO write-side clock.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port bclk, input, 1: serial audio bit clock, asynchronous to wclock.
REQ-007 SHALL have port lrck, input, 1: word select; 1 = left half, 0 = right half.
REQ-008 SHALL have port sdat, input, 1: serial data, MSB first, right-justified in each half.
REQ-009 SHALL have port wrfull, input, 1: audio FIFO full.
REQ-010 SHALL have port wrreq, output, 1: FIFO write strobe.
REQ-011 SHALL have port wrdata, output, 32: {left[15:0], right[15:0]}.
REQ-012 SHALL have port locked, output, 1: stream framing valid.
REQ-013 SHALL have port overflow, output, 1: sticky flag; a frame was dropped on wrfull.
REQ-014 SHALL have port drop_count, output, 8: saturating count of dropped frames.

Function
REQ-015 SHALL pass bclk, lrck and sdat through identical 2-flop synchronizers plus one history register, so all three keep their mutual alignment.
REQ-016 SHALL detect a bclk rise when synced bclk = 1 and history = 0; it SHALL detect an lrck edge when synced lrck differs from history.
REQ-017 On each bclk rise SHALL shift the synchronized sdat into a SAMPLE_BITS shift register, LSB end, and SHALL increment bit_cnt (6-bit, saturating at 63).
REQ-018 State machine SHALL have states SYNC, LEFT, RIGHT; reset SHALL enter SYNC.
REQ-019 In SYNC, a falling lrck edge SHALL go to RIGHT and a rising edge SHALL go to LEFT; no sample is latched on SYNC exits.
REQ-020 LEFT -> RIGHT on a falling lrck edge SHALL latch the shift register into left_hold.
REQ-021 RIGHT -> LEFT on a rising lrck edge SHALL latch the shift register as right and SHALL form the frame {left_hold, right}.
REQ-022 Every lrck edge SHALL clear bit_cnt to 0, or to 1 if a bclk rise occurs in the same cycle.
REQ-023 If a bclk rise and an lrck edge coincide, the latch SHALL use the pre-shift register value, and the new bit SHALL belong to the new half.
REQ-024 A half is good iff bit_cnt == BCLK_PER_HALF at its ending edge. A frame is good iff both of its halves are good.
REQ-025 A bad half SHALL force state SYNC, clear locked and clear the good-frame counter; that frame SHALL NOT be written.
REQ-026 locked SHALL assert after LOCK_FRAMES consecutive good frames and SHALL stay asserted until a bad half or reset.
REQ-027 A frame SHALL be written only when it is good and locked = 1, including when locked asserts on that same frame.
REQ-028 The write SHALL occur in the cycle after the RIGHT -> LEFT detection cycle: wrreq = 1 for exactly one cycle, with wrdata stable in that cycle.
REQ-029 If wrfull = 1 in the write cycle, wrreq SHALL stay 0 and the frame SHALL be discarded.
REQ-030 A discarded frame SHALL set overflow and increment drop_count, saturating at 255.
REQ-031 wrdata SHALL hold its last written value between writes.
REQ-032 Total latency SHALL be at most 4 wclock cycles from the lrck rising pin edge to wrreq.
REQ-033 wclock SHALL be at least 4x bclk; below that, behaviour is undefined.

Reset
REQ-034 While reset_n = 0, all outputs SHALL be 0, state = SYNC, synchronizers = 0, and all counters and holds = 0.
REQ-035 A mid-frame reset SHALL discard partial data; after release, the first write SHALL need a fresh SYNC exit plus LOCK_FRAMES good frames.
REQ-036 overflow and drop_count SHALL clear only on reset.

Verification
REQ-037 Nominal stream (wclock 54 MHz, bclk 2.8224 MHz, 32 bclk/half, L=16'hA5C3, R=16'h3C5A) -> locked rises at the end of frame 2, and wrdata = 32'hA5C33C5A with wrreq pulsed once per frame.
REQ-038 Hold wrfull = 1 for 3 frames while locked -> no wrreq, overflow = 1, drop_count = 3; then wrfull = 0 -> next frame written.
REQ-039 Inject a 31-bclk right half -> locked = 0, no write for that frame, locked re-asserts after 2 good frames.
REQ-040 Pulse reset_n low mid left half -> outputs 0 at once; first wrreq comes at the third rising lrck edge after release.
REQ-041 Skew lrck so its edge lands in the same wclock cycle as a bclk rise -> MSB is kept, and samples L=16'h8001, R=16'h0001 are captured exactly.
REQ-042 Force 300 drops -> drop_count saturates at 8'hFF.

Source files
------------

// File: rtl/audio_serial_capture.sv
// Captures a right-justified serial audio stream (bclk/lrck/sdat) into the wclock domain,
// checks framing, and emits one {left, right} FIFO write per good frame once locked.
`timescale 1ns/100ps

module audio_serial_capture #(
    parameter int SAMPLE_BITS   = 16,
    parameter int BCLK_PER_HALF = 32,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic                     wclock,
    input  logic                     reset_n,
    input  logic                     bclk,
    input  logic                     lrck,
    input  logic                     sdat,
    input  logic                     wrfull,
    output logic                     wrreq,
    output logic [2*SAMPLE_BITS-1:0] wrdata,
    output logic                     locked,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int              GW       = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]   LOCK_N   = GW'(LOCK_FRAMES);
    localparam logic [5:0]      HALF_LEN = 6'(BCLK_PER_HALF);
    localparam logic [5:0]      CNT_MAX  = 6'd63;

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    // Bit order in each stage: {sdat, lrck, bclk}; one chain keeps the three aligned.
    logic [2:0] sync_s1;
    logic [2:0] sync_s2;
    logic [2:0] sync_h;

    logic bclk_rise;
    logic lrck_edge;
    logic lrck_rise;
    logic lrck_fall;
    logic sdat_bit;

    logic [SAMPLE_BITS-1:0]   shreg;
    logic [5:0]               bit_cnt;
    logic                     half_good;

    state_t                   state;
    logic [SAMPLE_BITS-1:0]   left_hold;
    logic                     left_valid;
    logic [GW-1:0]            good_cnt;
    logic [GW-1:0]            good_next;
    logic                     lock_now;
    logic                     bad_half;
    logic                     close_left;
    logic                     close_right;

    logic                     wr_pend;
    logic [2*SAMPLE_BITS-1:0] frame;
    logic [2*SAMPLE_BITS-1:0] last_data;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours and the chain shifts by one stage.
    always_ff @(posedge wclock or negedge reset_n) begin
        if (!reset_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            sync_h  <= '0;
        end else begin
            sync_s1 <= {sdat, lrck, bclk};
            sync_s2 <= sync_s1;
            sync_h  <= sync_s2;
        end
    end

    assign bclk_rise = sync_s2[0] & ~sync_h[0];
    assign lrck_edge = sync_s2[1] ^ sync_h[1];
    assign lrck_rise = lrck_edge & sync_s2[1];
    assign lrck_fall = lrck_edge & ~sync_s2[1];
    // Data sampled one wclock before the visible rise: mid low phase, well away from transitions.
    assign sdat_bit  = sync_h[2];

    always_ff @(posedge wclock or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (bclk_rise)
                shreg <= {shreg[SAMPLE_BITS-2:0], sdat_bit};
            if (lrck_edge)
                bit_cnt <= bclk_rise ? 6'd1 : 6'd0;
            else if (bclk_rise && bit_cnt != CNT_MAX)
                bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // bit_cnt here is the pre-edge count, so a coincident bclk rise is charged to the new half.
    assign half_good = (bit_cnt == HALF_LEN);
    assign good_next = (good_cnt == LOCK_N) ? good_cnt : good_cnt + GW'(1);
    assign lock_now  = (good_next == LOCK_N);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        bad_half    = 1'b0;
        close_left  = 1'b0;
        close_right = 1'b0;
        case (state)
            LEFT: begin
                bad_half   = lrck_rise | (lrck_fall & ~half_good);
                close_left = lrck_fall & half_good;
            end
            RIGHT: begin
                bad_half    = lrck_fall | (lrck_rise & ~half_good);
                close_right = lrck_rise & half_good;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wclock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SYNC;
            left_hold  <= '0;
            left_valid <= 1'b0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            wr_pend    <= 1'b0;
            frame      <= '0;
        end else begin
            wr_pend <= 1'b0;
            if (bad_half) begin
                state      <= SYNC;
                locked     <= 1'b0;
                good_cnt   <= '0;
                left_valid <= 1'b0;
            end else begin
                case (state)
                    SYNC: begin
                        if (lrck_rise)
                            state <= LEFT;
                        else if (lrck_fall)
                            state <= RIGHT;
                    end
                    LEFT: begin
                        if (close_left) begin
                            state      <= RIGHT;
                            left_hold  <= shreg;
                            left_valid <= 1'b1;
                        end
                    end
                    RIGHT: begin
                        if (close_right) begin
                            state      <= LEFT;
                            left_valid <= 1'b0;
                            // A right half entered straight from SYNC has no left partner.
                            if (left_valid) begin
                                good_cnt <= good_next;
                                if (lock_now) begin
                                    locked  <= 1'b1;
                                    wr_pend <= 1'b1;
                                    frame   <= {left_hold, shreg};
                                end
                            end
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

    always_ff @(posedge wclock or negedge reset_n) begin
        if (!reset_n) begin
            last_data  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (wr_pend) begin
            if (wrfull) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'd1;
            end else begin
                last_data <= frame;
            end
        end
    end

    // The FIFO full flag is honoured in the write cycle itself; wrdata shows the
    // pending frame only when it is actually written, otherwise the last written one.
    assign wrreq  = wr_pend & ~wrfull;
    assign wrdata = wrreq ? frame : last_data;

endmodule

// File: tb/tb_audio_serial_capture.sv
// Directed stream bench for audio_serial_capture: frames are queued as expected writes
// when sent, and a monitor on the opposite wclock edge checks every wrreq against the queue.
`timescale 1ns/100ps

module tb_audio_serial_capture;

    localparam int SB    = 16;
    localparam int HALF  = 16;
    localparam int LOCKF = 2;

    logic          wclock  = 1'b0;
    logic          reset_n = 1'b0;
    logic          bclk    = 1'b0;
    logic          lrck    = 1'b0;
    logic          sdat    = 1'b0;
    logic          wrfull  = 1'b0;
    logic          wrreq;
    logic [2*SB-1:0] wrdata;
    logic          locked;
    logic          overflow;
    logic [7:0]    drop_count;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [31:0]   exp_q[$];
    logic          prev_wrreq  = 1'b0;

    audio_serial_capture #(
        .SAMPLE_BITS  (SB),
        .BCLK_PER_HALF(HALF),
        .LOCK_FRAMES  (LOCKF)
    ) dut (
        .wclock    (wclock),
        .reset_n   (reset_n),
        .bclk      (bclk),
        .lrck      (lrck),
        .sdat      (sdat),
        .wrfull    (wrfull),
        .wrreq     (wrreq),
        .wrdata    (wrdata),
        .locked    (locked),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    // 100 MHz wclock; bclk period 46 ns, so wclock is about 4.6x bclk.
    always #5 wclock = ~wclock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge wclock) begin
        if (wrreq === 1'b1) begin
            check("wrreq_single_cycle", 32'(prev_wrreq), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got wrdata %h, expected no write", wrdata);
            end else begin
                check("wrdata", wrdata, exp_q.pop_front());
            end
        end
        prev_wrreq = wrreq;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_wrreq"},      32'(wrreq),      32'd0);
        check({tag, "_wrdata"},     wrdata,          32'd0);
        check({tag, "_locked"},     32'(locked),     32'd0);
        check({tag, "_overflow"},   32'(overflow),   32'd0);
        check({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    endtask

    // One lrck half: lrck changes with the bclk fall before the first bit, or with the
    // first bclk rise when skew is set. rst_bit >= 0 pulses reset_n inside this half.
    task automatic send_half(input logic lr, input logic [15:0] data, input int nbits,
                             input bit skew, input int rst_bit);
        int idx;
        for (int i = 0; i < nbits; i++) begin
            idx  = nbits - 1 - i;
            sdat = data[idx];
            if (i == 0 && !skew) lrck = lr;
            if (rst_bit >= 0 && i == rst_bit + 3) reset_n = 1'b1;
            if (i == rst_bit) begin
                reset_n = 1'b0;
                #2;
                check_all_zero("in_reset");
                #21;
            end else begin
                #23;
            end
            bclk = 1'b1;
            if (i == 0 && skew) lrck = lr;
            #23;
            bclk = 1'b0;
        end
    endtask

    // Sends one frame; wrfull is applied from the right half on, so it is what this
    // frame's write cycle sees (just after the next frame's rising lrck edge).
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit exp_w,
                              input logic full, input int rbits, input bit skew,
                              input int rst_bit);
        if (exp_w) exp_q.push_back({l, r});
        send_half(1'b1, l, HALF, skew, rst_bit);
        wrfull = full;
        send_half(1'b0, r, rbits, skew, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] kk;
        #20.3;
        check_all_zero("reset");
        reset_n = 1'b1;
        #10;
        send_half(1'b0, 16'h0000, HALF, 1'b0, -1);

        // Nominal: the SYNC exit starts frame 1; locked and the first write follow frame 2.
        send_frame(16'hA5C3, 16'h3C5A, 1'b0, 1'b0, HALF, 1'b0, -1);
        check("locked_after_f1", 32'(locked), 32'd0);
        send_frame(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, HALF, 1'b0, -1);
        check("locked_before_f2_close", 32'(locked), 32'd0);
        send_frame(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, HALF, 1'b0, -1);
        check("locked_after_f2_close", 32'(locked), 32'd1);
        send_frame(16'h1234, 16'hABCD, 1'b1, 1'b0, HALF, 1'b0, -1);
        send_frame(16'hFFFF, 16'h0000, 1'b1, 1'b0, HALF, 1'b0, -1);

        // Three frames dropped on wrfull, then the next one written.
        send_frame(16'h1111, 16'h2222, 1'b0, 1'b1, HALF, 1'b0, -1);
        send_frame(16'h3333, 16'h4444, 1'b0, 1'b1, HALF, 1'b0, -1);
        send_frame(16'h5555, 16'h6666, 1'b0, 1'b1, HALF, 1'b0, -1);
        send_frame(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, HALF, 1'b0, -1);
        check("overflow_after_3_drops", 32'(overflow), 32'd1);
        check("drop_count_after_3_drops", 32'(drop_count), 32'd3);
        check("wrdata_held", wrdata, 32'hFFFF0000);
        check("locked_through_drops", 32'(locked), 32'd1);

        // A short right half breaks lock; two good frames after resync restore it.
        send_frame(16'h1357, 16'h2468, 1'b1, 1'b0, HALF, 1'b0, -1);
        send_frame(16'h9999, 16'h7777, 1'b0, 1'b0, HALF - 1, 1'b0, -1);
        send_frame(16'hA5C3, 16'h3C5A, 1'b0, 1'b0, HALF, 1'b0, -1);
        check("locked_after_short_half", 32'(locked), 32'd0);
        send_frame(16'hA5C3, 16'h3C5A, 1'b0, 1'b0, HALF, 1'b0, -1);
        check("locked_during_resync", 32'(locked), 32'd0);
        send_frame(16'hC0DE, 16'hBEEF, 1'b1, 1'b0, HALF, 1'b0, -1);

        // lrck edges coincide with a bclk rise: MSB must land in the new half.
        send_frame(16'h8001, 16'h0001, 1'b1, 1'b0, HALF, 1'b1, -1);
        check("locked_reacquired", 32'(locked), 32'd1);
        send_frame(16'h8001, 16'h0001, 1'b1, 1'b0, HALF, 1'b1, -1);
        send_frame(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, HALF, 1'b0, -1);
        check("locked_after_skew", 32'(locked), 32'd1);

        // Reset mid left half; first write comes at the third rising lrck edge after release.
        send_frame(16'hDEAD, 16'hBEEF, 1'b0, 1'b0, HALF, 1'b0, 5);
        send_frame(16'h1111, 16'h1111, 1'b0, 1'b0, HALF, 1'b0, -1);
        check("locked_after_reset_f1", 32'(locked), 32'd0);
        send_frame(16'h2222, 16'h3333, 1'b1, 1'b0, HALF, 1'b0, -1);
        check("overflow_cleared_by_reset", 32'(overflow), 32'd0);

        // 300 drops saturate drop_count.
        for (int k = 0; k < 300; k++) begin
            kk = 12'(k);
            send_frame({4'hE, kk}, {4'h7, ~kk}, 1'b0, 1'b1, HALF, 1'b0, -1);
        end
        send_frame(16'hCAFE, 16'hF00D, 1'b1, 1'b0, HALF, 1'b0, -1);
        check("drop_count_saturated", 32'(drop_count), 32'd255);
        check("overflow_sticky", 32'(overflow), 32'd1);
        check("locked_after_drops", 32'(locked), 32'd1);
        send_frame(16'h5A5A, 16'hA5A5, 1'b1, 1'b0, HALF, 1'b0, -1);
        send_half(1'b1, 16'h0000, HALF, 1'b0, -1);

        repeat (20) @(negedge wclock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
